sev_seg_capture: RTL and testbench
==================================

// Module: sev_seg_capture
// PURPOSE
//  Receive-side counterpart of the multiplexed 7-segment display driver: watches the
//  time-multiplexed segment bus (sev_seg_leds + led_enable) and reconstructs the four
//  displayed hex digits plus decimal points. Used as an on-chip/self-check monitor for
//  the adder-subtractor display path and as the scoreboard front end in display benches.
// PARAMETERS
//  SYNC_STAGES    2   synchroniser depth on sev_seg_leds/led_enable (>=2)
//  SETTLE_CYCLES  16  cycles a bus value must be unchanged before acceptance (1..255)
//  CNT_W          8   width of settle counter; must hold SETTLE_CYCLES
// PORTS
//  clk_main     in   1  system clock
//  reset        in   1  asynchronous, active-low reset
//  sev_seg_leds in   8  segments, active-low: [6:0]=g,f,e,d,c,b,a; [7]=dp
//  led_enable   in   4  digit enables, active-low; [0]->num_1 ... [3]->num_4
//  clear_err    in   1  synchronous pulse: clears err_seg, err_multi
//  num_1..num_4 out  4  decoded digit values (each 4 bits), updated together per frame
//  dp           out  4  decoded decimal points, dp[i] pairs with num_(i+1), 1=lit
//  digit_valid  out  4  digit i captured since last frame_valid
//  frame_valid  out  1  1-cycle pulse: all four digits captured, num_*/dp just updated
//  err_seg      out  1  sticky: accepted segment pattern not a legal hex glyph
//  err_multi    out  1  sticky: accepted led_enable had >1 digit low
// BEHAVIOUR
//  - Reset (async assert, sync release): num_*=0, dp=0, digit_valid=0, frame_valid=0,
//    errors=0, synchronisers to all-ones (blank), FSM=IDLE, counter=0.
//  - Inputs pass SYNC_STAGES flops; all logic below uses synchronised copies s_seg/s_en.
//  - Stability: 12-bit {s_en,s_seg} compared with previous cycle; any change reloads
//    counter to 0. Counter saturates at SETTLE_CYCLES.
//  - FSM: IDLE (s_en=4'hF, blank) -> SETTLE on any enable low; SETTLE -> ACCEPT when
//    counter==SETTLE_CYCLES-1 and bus unchanged; ACCEPT lasts 1 cycle -> HOLD;
//    HOLD -> SETTLE on any bus change, -> IDLE if bus goes blank. SETTLE -> IDLE on blank.
//  - ACCEPT actions (one cycle): exactly one enable low -> decode ~s_seg[6:0] via
//    standard 0-F glyph table (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,
//    A=77,b=7C,C=39,d=5E,E=79,F=71, active-high gfedcba) into shadow[i], shadow_dp[i],
//    set digit_valid[i]. Illegal glyph: set err_seg, do not store, digit_valid unchanged.
//    >1 enable low: set err_multi, store nothing.
//  - Same digit accepted twice before frame completes: shadow overwritten (latest wins).
//  - Frame: cycle after digit_valid becomes 4'hF: copy shadow->num_*/dp, frame_valid=1
//    for one cycle, digit_valid cleared same edge. Accept in that same cycle is
//    counted toward the next frame (its bit set after the clear).
//  - Latency: input edge -> ACCEPT = SYNC_STAGES + SETTLE_CYCLES cycles; last digit
//    ACCEPT -> frame_valid = 2 cycles.
//  - clear_err concurrent with a new error: error wins (stays 1).
//  - Settle counter width: saturating, never wraps. Reset mid-frame discards shadows.
// STRUCTURE
//  - Shared package sev_seg_pkg: glyph constants GLYPH_0..GLYPH_F, SEG_BLANK=8'hFF,
//    EN_NONE=4'hF, FSM state enum {IDLE,SETTLE,ACCEPT,HOLD}.
//  - One sub-module: sev_seg_glyph_decode (combinational 7-bit -> {legal,4-bit value});
//    synchroniser, stability counter, FSM, shadow/output regs stay in top.
// TESTING
//  - Reset: drive reset=0 mid-activity -> all outputs 0 immediately; release, blank
//    bus -> FSM IDLE, no flags.
//  - Frame: drive driver-style scan of 1,2,3,4 (8'hF9,A4,B0,99 on en E,D,B,7, 64 clk each)
//    -> frame_valid pulse once, num_1=1,num_2=2,num_3=3,num_4=4, dp=0.
//  - Glitch: change segments for SETTLE_CYCLES-1 cycles then revert -> no accept,
//    digit_valid unchanged; hold SETTLE_CYCLES -> accepted.
//  - Illegal glyph 8'hFE on digit 0 -> err_seg=1, digit_valid[0]=0; clear_err -> 0.
//  - led_enable=4'b1100 stable -> err_multi=1, no digit stored; clear_err with new
//    error same cycle -> err_multi stays 1.
//  - Overwrite/dp: digit 0 shows A then F with dp lit (8'h0E), others 0 -> num_1=F,
//    dp[0]=1 at frame_valid; next frame starts with digit_valid=0.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared constants and types for the 7-segment capture path.
//   GLYPH_0..GLYPH_F : active-high gfedcba patterns of the standard hex glyphs
//   SEG_BLANK        : segment bus value with every segment (and dp) dark
//   EN_NONE          : digit-enable value with no digit selected
//   state_t          : capture FSM states
package sev_seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] EN_NONE   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCEPT,
    HOLD
  } state_t;

endpackage

// File: rtl/sev_seg_glyph_decode.sv
// sev_seg_glyph_decode: combinational glyph -> hex value lookup.
//   glyph [6:0] in  : active-high segment pattern, gfedcba
//   legal       out : 1 when glyph is one of the 16 hex glyphs
//   value [3:0] out : decoded hex value (0 when not legal)
module sev_seg_glyph_decode
  import sev_seg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       legal,
  output logic [3:0] value
);

  always_comb begin
    legal = 1'b1;
    value = 4'h0;
    case (glyph)
      GLYPH_0: value = 4'h0;
      GLYPH_1: value = 4'h1;
      GLYPH_2: value = 4'h2;
      GLYPH_3: value = 4'h3;
      GLYPH_4: value = 4'h4;
      GLYPH_5: value = 4'h5;
      GLYPH_6: value = 4'h6;
      GLYPH_7: value = 4'h7;
      GLYPH_8: value = 4'h8;
      GLYPH_9: value = 4'h9;
      GLYPH_A: value = 4'hA;
      GLYPH_B: value = 4'hB;
      GLYPH_C: value = 4'hC;
      GLYPH_D: value = 4'hD;
      GLYPH_E: value = 4'hE;
      GLYPH_F: value = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sev_seg_capture.sv
// sev_seg_capture: rebuilds the four hex digits shown on a time-multiplexed
// 7-segment bus.
//   clk_main          in  : system clock
//   reset             in  : asynchronous active-low reset
//   sev_seg_leds[7:0] in  : segments, active-low; [6:0]=gfedcba, [7]=dp
//   led_enable[3:0]   in  : digit enables, active-low; bit i -> num_(i+1)
//   clear_err         in  : synchronous pulse clearing err_seg/err_multi
//   num_1..num_4[3:0] out : decoded digits, updated together once per frame
//   dp[3:0]           out : decoded decimal points, 1 = lit
//   digit_valid[3:0]  out : digit captured since the last frame_valid
//   frame_valid       out : 1-cycle pulse when num_*/dp were just updated
//   err_seg           out : sticky, an accepted pattern was not a hex glyph
//   err_multi         out : sticky, an accepted enable had >1 digit low
module sev_seg_capture
  import sev_seg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic [7:0] sev_seg_leds,
  input  logic [3:0] led_enable,
  input  logic       clear_err,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic [3:0] num_3,
  output logic [3:0] num_4,
  output logic [3:0] dp,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic       err_seg,
  output logic       err_multi
);

  logic [7:0]       seg_sync [SYNC_STAGES];
  logic [3:0]       en_sync  [SYNC_STAGES];
  logic [7:0]       s_seg;
  logic [3:0]       s_en;
  logic [11:0]      bus_prev;
  logic             changed;
  logic [CNT_W-1:0] cnt;
  state_t           state_q, state_d;

  logic       one_low;
  logic       multi_low;
  logic [1:0] idx;
  logic       glyph_legal;
  logic [3:0] glyph_value;
  logic       acc_store, acc_seg_err, acc_multi;
  logic       frame_now;
  logic [3:0] shadow [4];
  logic [3:0] shadow_dp;

  // Synchronisers reset to the blank bus so release never looks like activity.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= SEG_BLANK;
        en_sync[i]  <= EN_NONE;
      end
    end else begin
      seg_sync[0] <= sev_seg_leds;
      en_sync[0]  <= led_enable;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= seg_sync[i-1];
        en_sync[i]  <= en_sync[i-1];
      end
    end
  end

  assign s_seg   = seg_sync[SYNC_STAGES-1];
  assign s_en    = en_sync[SYNC_STAGES-1];
  assign changed = ({s_en, s_seg} != bus_prev);

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      bus_prev <= {EN_NONE, SEG_BLANK};
      cnt      <= '0;
    end else begin
      bus_prev <= {s_en, s_seg};
      if (changed)
        cnt <= '0;
      else if (cnt < CNT_W'(SETTLE_CYCLES))
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_en != EN_NONE) state_d = SETTLE;
      SETTLE: begin
        if (s_en == EN_NONE)
          state_d = IDLE;
        else if (!changed && cnt == CNT_W'(SETTLE_CYCLES - 1))
          state_d = ACCEPT;
      end
      ACCEPT:  state_d = HOLD;
      HOLD: begin
        if (s_en == EN_NONE) state_d = IDLE;
        else if (changed)    state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx     = 2'd0;
    one_low = 1'b1;
    case (s_en)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign multi_low = !one_low && (s_en != EN_NONE);

  sev_seg_glyph_decode u_decode (
    .glyph (~s_seg[6:0]),
    .legal (glyph_legal),
    .value (glyph_value)
  );

  assign acc_store   = (state_q == ACCEPT) && one_low && glyph_legal;
  assign acc_seg_err = (state_q == ACCEPT) && one_low && !glyph_legal;
  assign acc_multi   = (state_q == ACCEPT) && multi_low;
  assign frame_now   = (digit_valid == 4'hF);

  // The frame clear and a same-cycle accept are merged so that accept lands
  // in the next frame; ~s_en is the one-hot digit mask when one_low holds.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
      shadow_dp   <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      num_1       <= '0;
      num_2       <= '0;
      num_3       <= '0;
      num_4       <= '0;
      dp          <= '0;
      err_seg     <= 1'b0;
      err_multi   <= 1'b0;
    end else begin
      if (acc_store) begin
        shadow[idx]    <= glyph_value;
        shadow_dp[idx] <= ~s_seg[7];
      end
      digit_valid <= (frame_now ? 4'h0 : digit_valid) | (acc_store ? ~s_en : 4'h0);
      frame_valid <= frame_now;
      if (frame_now) begin
        num_1 <= shadow[0];
        num_2 <= shadow[1];
        num_3 <= shadow[2];
        num_4 <= shadow[3];
        dp    <= shadow_dp;
      end
      err_seg   <= acc_seg_err || (err_seg   && !clear_err);
      err_multi <= acc_multi   || (err_multi && !clear_err);
    end
  end

endmodule

// File: tb/tb_sev_seg_capture.sv
module tb_sev_seg_capture;

  localparam int unsigned S = 16;

  logic       clk_main = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sev_seg_leds = 8'hFF;
  logic [3:0] led_enable = 4'hF;
  logic       clear_err = 1'b0;
  logic [3:0] num_1, num_2, num_3, num_4, dp, digit_valid;
  logic       frame_valid, err_seg, err_multi;

  sev_seg_capture #(.SYNC_STAGES(2), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk_main     (clk_main),
    .reset        (reset),
    .sev_seg_leds (sev_seg_leds),
    .led_enable   (led_enable),
    .clear_err    (clear_err),
    .num_1        (num_1),
    .num_2        (num_2),
    .num_3        (num_3),
    .num_4        (num_4),
    .dp           (dp),
    .digit_valid  (digit_valid),
    .frame_valid  (frame_valid),
    .err_seg      (err_seg),
    .err_multi    (err_multi)
  );

  always #5 clk_main = ~clk_main;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] nums;   // {num_4,num_3,num_2,num_1}
    logic [3:0]  dps;
  } frame_t;

  frame_t exp_q[$];

  // Reference model state: what the display has committed to so far.
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_dv = 4'h0;
  logic        m_err_seg = 1'b0;
  logic        m_err_multi = 1'b0;
  logic [11:0] m_prev = 12'hFFF;

  function automatic logic [6:0] glyph_of(input int unsigned v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A bus value shown long enough: interpret it the way a viewer would.
  task automatic model_accept(input logic [3:0] en, input logic [7:0] seg);
    logic [3:0] low;
    int         pos;
    bit         found;
    logic [3:0] val;
    low = ~en;
    if ($countones(low) > 1) begin
      m_err_multi = 1'b1;
      return;
    end
    pos = 0;
    for (int i = 0; i < 4; i++) if (low[i]) pos = i;
    found = 1'b0;
    val = 4'h0;
    for (int v = 0; v < 16; v++)
      if (glyph_of(v) == ~seg[6:0]) begin
        found = 1'b1;
        val = 4'(v);
      end
    if (!found) begin
      m_err_seg = 1'b1;
      return;
    end
    m_shadow[pos] = val;
    m_dp[pos] = ~seg[7];
    m_dv[pos] = 1'b1;
    if (m_dv == 4'hF) begin
      exp_q.push_back('{nums: {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]}, dps: m_dp});
      m_dv = 4'h0;
    end
  endtask

  // Called at a negedge; holds the bus for cyc sampling edges.
  task automatic drive(input logic [3:0] en, input logic [7:0] seg, input int unsigned cyc);
    if (cyc >= S + 8 && {en, seg} != m_prev && en != 4'hF) model_accept(en, seg);
    m_prev = {en, seg};
    led_enable = en;
    sev_seg_leds = seg;
    repeat (cyc) @(negedge clk_main);
    chk("digit_valid", {28'h0, digit_valid}, {28'h0, m_dv});
    chk("err_seg", {31'h0, err_seg}, {31'h0, m_err_seg});
    chk("err_multi", {31'h0, err_multi}, {31'h0, m_err_multi});
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk_main);
    clear_err = 1'b0;
    m_err_seg = 1'b0;
    m_err_multi = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nums"}, {16'h0, num_4, num_3, num_2, num_1}, 32'h0);
    chk({tag, "_dp"}, {28'h0, dp}, 32'h0);
    chk({tag, "_dv"}, {28'h0, digit_valid}, 32'h0);
    chk({tag, "_fv"}, {31'h0, frame_valid}, 32'h0);
    chk({tag, "_errs"}, {30'h0, err_seg, err_multi}, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_dp = 4'h0;
    m_dv = 4'h0;
    m_err_seg = 1'b0;
    m_err_multi = 1'b0;
    m_prev = 12'hFFF;
  endtask

  task automatic frame_1234();
    drive(4'hE, 8'hF9, 64);
    drive(4'hD, 8'hA4, 64);
    drive(4'hB, 8'hB0, 64);
    drive(4'h7, 8'h99, 64);
  endtask

  // Monitor: every frame_valid pulse is matched against the oldest expected frame.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk_main);
      if (frame_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected actual=%0h%0h%0h%0h expected=none at %0t",
                   num_4, num_3, num_2, num_1, $time);
        end else begin
          f = exp_q.pop_front();
          chk("frame_nums", {16'h0, num_4, num_3, num_2, num_1}, {16'h0, f.nums});
          chk("frame_dp", {28'h0, dp}, {28'h0, f.dps});
          chk("frame_dv_cleared", {28'h0, digit_valid}, 32'h0);
        end
      end
    end
  end

  initial begin
    logic [3:0]  en;
    logic [7:0]  seg;
    int unsigned cyc;
    int unsigned r;
    int          waited;

    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk_main);
    chk_all_zero("reset_init");
    reset = 1'b1;
    @(negedge clk_main);
    drive(4'hF, 8'hFF, 20);

    frame_1234();

    // Short glitch on digit 0 must not be captured.
    drive(4'hE, 8'hC0, 40);
    drive(4'hE, 8'hF9, S - 1);
    drive(4'hE, 8'hC0, 40);
    drive(4'hD, 8'hC0, 40);
    drive(4'hB, 8'hC0, 40);
    drive(4'h7, 8'hC0, 40);

    // Illegal glyph on digit 0.
    drive(4'hE, 8'hFE, 40);
    chk("illegal_dv0", {31'h0, digit_valid[0]}, 32'h0);
    chk("illegal_err_seg", {31'h0, err_seg}, 32'h1);
    pulse_clear();
    @(negedge clk_main);
    chk("cleared_err_seg", {31'h0, err_seg}, 32'h0);

    // Two digits enabled at once.
    drive(4'b1100, 8'hC0, 40);
    chk("multi_err", {31'h0, err_multi}, 32'h1);
    chk("multi_no_store", {28'h0, digit_valid}, 32'h0);
    pulse_clear();
    @(negedge clk_main);
    chk("cleared_err_multi", {31'h0, err_multi}, 32'h0);

    // clear_err coincides with the accept cycle of a new multi-enable error.
    model_accept(4'b0011, 8'hC0);
    m_prev = {4'b0011, 8'hC0};
    led_enable = 4'b0011;
    sev_seg_leds = 8'hC0;
    repeat (S + 3) @(negedge clk_main);
    clear_err = 1'b1;
    @(negedge clk_main);
    clear_err = 1'b0;
    repeat (10) @(negedge clk_main);
    chk("err_wins_over_clear", {31'h0, err_multi}, 32'h1);
    pulse_clear();

    // Overwrite of digit 0; second value carries a lit dp.
    drive(4'hE, 8'h88, 40);
    drive(4'hE, 8'h0E, 40);
    drive(4'hD, 8'hC0, 40);
    drive(4'hB, 8'hC0, 40);
    drive(4'h7, 8'hC0, 40);
    chk("next_frame_dv", {28'h0, digit_valid}, 32'h0);

    // Randomized scan traffic.
    for (int k = 0; k < 150; k++) begin
      do begin
        r = $urandom_range(0, 19);
        if (r < 15) en = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 17) en = 4'hF;
        else begin
          do en = 4'($urandom); while ($countones(~en) < 2);
        end
        if ($urandom_range(0, 19) == 0) seg = 8'($urandom);
        else seg = {1'($urandom_range(0, 1)), ~glyph_of($urandom_range(0, 15))};
        cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S + 8, S + 40);
      end while ({en, seg} == m_prev);
      drive(en, seg, cyc);
      if (k % 25 == 24 && cyc >= S + 8) pulse_clear();
    end

    // Reset in the middle of a partial frame.
    drive(4'hE, 8'hF9, 40);
    drive(4'hD, 8'hA4, 40);
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_mid");
    model_reset();
    led_enable = 4'hF;
    sev_seg_leds = 8'hFF;
    repeat (3) @(negedge clk_main);
    reset = 1'b1;
    @(negedge clk_main);
    drive(4'hF, 8'hFF, 30);
    chk("post_reset_fv", {31'h0, frame_valid}, 32'h0);

    frame_1234();

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk_main);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL frames_outstanding actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
